// File: rtl/sv39_ptw_walker_if.sv
// sv39_ptw_walker_if: miss, PTE memory and TLB update/fault signals of the SV39 walker
interface sv39_ptw_walker_if #(
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 39,
    parameter int PLEN       = 56
);
    logic                  miss_valid_i;
    logic                  miss_ready_o;
    logic [VLEN-1:0]       miss_vaddr_i;
    logic [ASID_WIDTH-1:0] miss_asid_i;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [PLEN-1:0]       mem_req_addr_o;
    logic                  mem_rsp_valid_i;
    logic [63:0]           mem_rsp_data_i;
    logic                  mem_rsp_err_i;
    logic                  update_valid_o;
    logic [26:0]           update_vpn_o;
    logic [ASID_WIDTH-1:0] update_asid_o;
    logic                  update_is_1G_o;
    logic                  update_is_2M_o;
    logic [63:0]           update_content_o;
    logic                  fault_o;
    logic [VLEN-1:0]       fault_vaddr_o;

    modport master (
        input  miss_valid_i, miss_vaddr_i, miss_asid_i, mem_req_ready_i,
               mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        output miss_ready_o, mem_req_valid_o, mem_req_addr_o, update_valid_o,
               update_vpn_o, update_asid_o, update_is_1G_o, update_is_2M_o,
               update_content_o, fault_o, fault_vaddr_o
    );

    modport slave (
        output miss_valid_i, miss_vaddr_i, miss_asid_i, mem_req_ready_i,
               mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, update_valid_o,
               update_vpn_o, update_asid_o, update_is_1G_o, update_is_2M_o,
               update_content_o, fault_o, fault_vaddr_o
    );
endinterface

// File: rtl/sv39_ptw_walker.sv
// sv39_ptw_walker: SV39 page-table walker producing one TLB update or page fault per miss
module sv39_ptw_walker #(
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 39,
    parameter int PLEN       = 56
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [43:0]       satp_ppn_i,
    sv39_ptw_walker_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, UPDATE, FAULT, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [VLEN-1:0]       vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [43:0]           ppn_q;
    logic [1:0]            level_q;
    logic [63:0]           pte_q;
    logic                  is_1g_q, is_2m_q, flushed_q;
    logic [8:0]            vpn_idx;
    logic [55:0]           pte_addr;
    logic                  pte_leaf, misaligned, walk_fault;

    assign vpn_idx    = level_q == 2'd2 ? vaddr_q[38:30] : level_q == 2'd1 ? vaddr_q[29:21] : vaddr_q[20:12];
    assign pte_addr   = {ppn_q, vpn_idx, 3'b000};
    assign pte_leaf   = bus.mem_rsp_data_i[1] | bus.mem_rsp_data_i[3];
    assign misaligned = (level_q == 2'd2 && bus.mem_rsp_data_i[27:10] != 18'd0) ||
                        (level_q == 2'd1 && bus.mem_rsp_data_i[18:10] != 9'd0);
    // A pointer at level 0 has nowhere left to go, so it faults like a bad leaf.
    assign walk_fault = bus.mem_rsp_err_i | ~bus.mem_rsp_data_i[0] |
                        (~bus.mem_rsp_data_i[1] & bus.mem_rsp_data_i[2]) |
                        (pte_leaf ? misaligned : level_q == 2'd0);

    assign bus.miss_ready_o     = state_q == IDLE;
    assign bus.mem_req_valid_o  = state_q == REQ;
    assign bus.mem_req_addr_o   = pte_addr[PLEN-1:0];
    assign bus.update_valid_o   = state_q == UPDATE && !flush_i;
    assign bus.fault_o          = state_q == FAULT && !flush_i;
    assign bus.update_vpn_o     = vaddr_q[38:12];
    assign bus.update_asid_o    = asid_q;
    assign bus.update_is_1G_o   = is_1g_q;
    assign bus.update_is_2M_o   = is_2m_q;
    assign bus.update_content_o = pte_q;
    assign bus.fault_vaddr_o    = vaddr_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a flushed walk still waits out its outstanding request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (bus.miss_valid_i) state_d = REQ;
            REQ:           if (bus.mem_req_ready_i) state_d = (flush_i || flushed_q) ? DRAIN : WAIT;
            WAIT:          if (flush_i) state_d = bus.mem_rsp_valid_i ? IDLE : DRAIN;
                           else if (bus.mem_rsp_valid_i) state_d = walk_fault ? FAULT : pte_leaf ? UPDATE : REQ;
            UPDATE, FAULT: state_d = IDLE;
            DRAIN:         if (bus.mem_rsp_valid_i) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // Walk context: miss capture, PTE capture, descent to the next level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vaddr_q   <= '0;
            asid_q    <= '0;
            ppn_q     <= '0;
            level_q   <= '0;
            pte_q     <= '0;
            is_1g_q   <= 1'b0;
            is_2m_q   <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.miss_valid_i) begin
                vaddr_q <= bus.miss_vaddr_i;
                asid_q  <= bus.miss_asid_i;
                ppn_q   <= satp_ppn_i;
                level_q <= 2'd2;
            end
            if (state_q == WAIT && bus.mem_rsp_valid_i && !flush_i) begin
                pte_q   <= bus.mem_rsp_data_i;
                is_1g_q <= level_q == 2'd2;
                is_2m_q <= level_q == 2'd1;
                if (!walk_fault && !pte_leaf) begin
                    ppn_q   <= bus.mem_rsp_data_i[53:10];
                    level_q <= level_q - 2'd1;
                end
            end
            flushed_q <= state_q == REQ && !bus.mem_req_ready_i && (flush_i || flushed_q);
        end
    end
endmodule

// File: tb/tb_sv39_ptw_walker.sv
// tb_sv39_ptw_walker: table-driven walks with a scoreboard on update/fault outcomes
module tb_sv39_ptw_walker;
    typedef struct packed {
        logic [43:0]       satp;
        logic [38:0]       va;
        logic              asid;
        int                nreq;
        int                stall;
        logic [0:2][63:0]  data;
        logic [0:2]        err;
        logic [0:2][55:0]  addr;
        logic              flt;
        logic              g1;
        logic              m2;
        logic [26:0]       vpn;
        int                lat;
    } vec_t;

    typedef struct packed {
        logic        flt;
        logic [26:0] vpn;
        logic        asid;
        logic        g1;
        logic        m2;
        logic [63:0] content;
        logic [38:0] va;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [43:0] satp = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    vec_t        vt[10];

    sv39_ptw_walker_if #(.ASID_WIDTH(1), .VLEN(39), .PLEN(56)) bus ();

    sv39_ptw_walker #(.ASID_WIDTH(1), .VLEN(39), .PLEN(56)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .satp_ppn_i (satp),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [43:0] s, input logic [38:0] va, input logic asid,
                                input int nreq, input int stall, input logic [63:0] d0, d1, d2,
                                input logic [0:2] err, input logic [55:0] a0, a1, a2,
                                input logic flt, g1, m2, input logic [26:0] vpn, input int lat);
        vec_t v;
        v.satp = s; v.va = va; v.asid = asid; v.nreq = nreq; v.stall = stall;
        v.data = {d0, d1, d2}; v.err = err; v.addr = {a0, a1, a2};
        v.flt = flt; v.g1 = g1; v.m2 = m2; v.vpn = vpn; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: every update/fault pulse must match the oldest expected outcome
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (bus.update_valid_o || bus.fault_o) begin
            if (sb.size() == 0) chk("spurious_outcome", 64'({bus.update_valid_o, bus.fault_o}), 64'd0);
            else begin
                e = sb.pop_front();
                chk("out_fault", 64'(bus.fault_o), 64'(e.flt));
                chk("out_update", 64'(bus.update_valid_o), 64'(!e.flt));
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
                if (e.flt) chk("fault_vaddr", 64'(bus.fault_vaddr_o), 64'(e.va));
                else begin
                    chk("upd_vpn", 64'(bus.update_vpn_o), 64'(e.vpn));
                    chk("upd_asid", 64'(bus.update_asid_o), 64'(e.asid));
                    chk("upd_1G", 64'(bus.update_is_1G_o), 64'(e.g1));
                    chk("upd_2M", 64'(bus.update_is_2M_o), 64'(e.m2));
                    chk("upd_content", bus.update_content_o, e.content);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_miss(input logic [43:0] s, input logic [38:0] va, input logic asid);
        satp = s;
        bus.miss_valid_i = 1'b1;
        bus.miss_vaddr_i = va;
        bus.miss_asid_i = asid;
        chk("miss_ready_at_accept", 64'(bus.miss_ready_o), 64'd1);
    endtask

    task automatic respond(input logic [63:0] d, input logic e);
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i = d;
        bus.mem_rsp_err_i = e;
        step();
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_err_i = 1'b0;
    endtask

    task automatic run_walk(input vec_t v);
        exp_t e;
        int   g;
        start_miss(v.satp, v.va, v.asid);
        e.flt = v.flt; e.vpn = v.vpn; e.asid = v.asid; e.g1 = v.g1; e.m2 = v.m2;
        e.content = v.data[v.nreq-1]; e.va = v.va; e.cyc = cyc + v.lat;
        sb.push_back(e);
        step();
        bus.miss_valid_i = 1'b0;
        for (int i = 0; i < v.nreq; i++) begin
            g = 0;
            while (!bus.mem_req_valid_o && g < 20) begin step(); g++; end
            chk("req_valid", 64'(bus.mem_req_valid_o), 64'd1);
            chk("req_addr", 64'(bus.mem_req_addr_o), 64'(v.addr[i]));
            if (i == 0) for (int s = 0; s < v.stall; s++) begin
                step();
                chk("stall_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
                chk("stall_req_addr", 64'(bus.mem_req_addr_o), 64'(v.addr[0]));
                chk("stall_miss_ready", 64'(bus.miss_ready_o), 64'd0);
            end
            bus.mem_req_ready_i = 1'b1;
            step();
            bus.mem_req_ready_i = 1'b0;
            respond(v.data[i], v.err[i]);
        end
        g = 0;
        while (!bus.miss_ready_o && g < 20) begin step(); g++; end
        chk("walk_done", 64'(bus.miss_ready_o), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.miss_valid_i = 1'b0;
        bus.miss_vaddr_i = '0;
        bus.miss_asid_i = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i = '0;
        bus.mem_rsp_err_i = 1'b0;

        vt[0] = mk(44'h80000, 39'h0040201000, 1'b1, 3, 0, 64'h20000401, 64'h20000801, 64'h200400CF, 3'b000,
                   56'h80000008, 56'h80001008, 56'h80002008, 1'b0, 1'b0, 1'b0, 27'h40201, 7);
        vt[1] = mk(44'h80000, 39'h0040201000, 1'b1, 1, 0, 64'h200000CF, 64'h0, 64'h0, 3'b000,
                   56'h80000008, 56'h0, 56'h0, 1'b0, 1'b1, 1'b0, 27'h40201, 3);
        vt[2] = mk(44'h80000, 39'h0040201000, 1'b1, 2, 0, 64'h20000401, 64'h200004CF, 64'h0, 3'b000,
                   56'h80000008, 56'h80001008, 56'h0, 1'b1, 1'b0, 1'b0, 27'h40201, 5);
        vt[3] = mk(44'h80000, 39'h0040201000, 1'b0, 1, 0, 64'h0, 64'h0, 64'h0, 3'b000,
                   56'h80000008, 56'h0, 56'h0, 1'b1, 1'b0, 1'b0, 27'h40201, 3);
        vt[4] = mk(44'h80000, 39'h0040201000, 1'b1, 3, 0, 64'h20000401, 64'h20000801, 64'h200400CF, 3'b001,
                   56'h80000008, 56'h80001008, 56'h80002008, 1'b1, 1'b0, 1'b0, 27'h40201, 7);
        vt[5] = mk(44'h80000, 39'h0040201000, 1'b0, 3, 3, 64'h20000401, 64'h20000801, 64'h200400CF, 3'b000,
                   56'h80000008, 56'h80001008, 56'h80002008, 1'b0, 1'b0, 1'b0, 27'h40201, 10);
        vt[6] = mk(44'h80000, 39'h0040201000, 1'b0, 2, 0, 64'h20000401, 64'h200000CF, 64'h0, 3'b000,
                   56'h80000008, 56'h80001008, 56'h0, 1'b0, 1'b0, 1'b1, 27'h40201, 5);
        vt[7] = mk(44'h80000, 39'h0040201000, 1'b1, 3, 0, 64'h20000401, 64'h20000801, 64'h20000C01, 3'b000,
                   56'h80000008, 56'h80001008, 56'h80002008, 1'b1, 1'b0, 1'b0, 27'h40201, 7);
        vt[8] = mk(44'h80000, 39'h0040201000, 1'b0, 1, 0, 64'h5, 64'h0, 64'h0, 3'b000,
                   56'h80000008, 56'h0, 56'h0, 1'b1, 1'b0, 1'b0, 27'h40201, 3);
        vt[9] = mk(44'h12345, 39'h4C8ABCD678, 1'b0, 1, 0, 64'h100000CF, 64'h0, 64'h0, 3'b000,
                   56'h12345990, 56'h0, 56'h0, 1'b0, 1'b1, 1'b0, 27'h4C8ABCD, 3);

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_miss_ready", 64'(bus.miss_ready_o), 64'd1);
        chk("rst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_req_addr", 64'(bus.mem_req_addr_o), 64'd0);
        chk("rst_update_valid", 64'(bus.update_valid_o), 64'd0);
        chk("rst_fault", 64'(bus.fault_o), 64'd0);
        chk("rst_content", bus.update_content_o, 64'd0);
        chk("rst_fault_vaddr", 64'(bus.fault_vaddr_o), 64'd0);
        step();

        for (int i = 0; i < 10; i++) run_walk(vt[i]);

        // Flush in WAIT at level 1; the late response is drained, then a new miss runs normally
        start_miss(44'h80000, 39'h0040201000, 1'b1);
        step();
        bus.miss_valid_i = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        respond(64'h20000401, 1'b0);
        chk("fl_wait_l1_addr", 64'(bus.mem_req_addr_o), 64'h80001008);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_wait_drain_ready", 64'(bus.miss_ready_o), 64'd0);
        chk("fl_wait_drain_req", 64'(bus.mem_req_valid_o), 64'd0);
        step();
        respond(64'h200400CF, 1'b0);
        chk("fl_wait_idle_after_rsp", 64'(bus.miss_ready_o), 64'd1);
        run_walk(vt[1]);

        // Flush in REQ while stalled: request stays up until accepted, then the response is drained
        start_miss(44'h80000, 39'h0040201000, 1'b0);
        step();
        bus.miss_valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_req_still_valid", 64'(bus.mem_req_valid_o), 64'd1);
        chk("fl_req_addr", 64'(bus.mem_req_addr_o), 64'h80000008);
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        chk("fl_req_drain_req", 64'(bus.mem_req_valid_o), 64'd0);
        chk("fl_req_drain_ready", 64'(bus.miss_ready_o), 64'd0);
        respond(64'h200000CF, 1'b0);
        chk("fl_req_idle", 64'(bus.miss_ready_o), 64'd1);

        // Flush during the UPDATE cycle suppresses the strobe
        start_miss(44'h80000, 39'h0040201000, 1'b1);
        step();
        bus.miss_valid_i = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        respond(64'h200000CF, 1'b0);
        flush_i = 1'b1;
        #1 chk("fl_upd_suppressed", 64'(bus.update_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        chk("fl_upd_idle", 64'(bus.miss_ready_o), 64'd1);

        // Asynchronous reset mid-walk; the stray response afterwards is ignored
        start_miss(44'h80000, 39'h0040201000, 1'b1);
        step();
        bus.miss_valid_i = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("arst_miss_ready", 64'(bus.miss_ready_o), 64'd1);
        chk("arst_fault_vaddr", 64'(bus.fault_vaddr_o), 64'd0);
        #1 rst_i = 1'b0;
        step();
        respond(64'h200000CF, 1'b0);
        chk("arst_stray_ignored", 64'(bus.miss_ready_o), 64'd1);
        chk("arst_content", bus.update_content_o, 64'd0);
        step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sv39_ptw_walker.md
# sv39_ptw_walker

Hardware page-table walker for SV39 that refills the per-port TLBs. It accepts a translation miss (virtual address plus ASID), performs up to three page-table reads on a single-outstanding memory request/response interface, and produces exactly one outcome per accepted miss:

- a TLB update (tag fields plus the leaf PTE), or
- a page-fault pulse.

It sits between the TLB miss path and the data-cache PTW port.

## Interface
- `ASID_WIDTH`, default 1: width of the ASID carried from miss to update.
- `VLEN`, default 39: virtual address width.
- `PLEN`, default 56: physical address width.

Ports (name, direction, width, meaning):
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: abort the current walk.
- `satp_ppn_i` in 44: root page-table PPN, sampled when a miss is accepted.
- `miss_valid_i` in 1, `miss_ready_o` out 1: miss handshake.
- `miss_vaddr_i` in VLEN: missing virtual address.
- `miss_asid_i` in ASID_WIDTH: ASID of the miss.
- `mem_req_valid_o` out 1, `mem_req_ready_i` in 1: PTE read request handshake.
- `mem_req_addr_o` out PLEN: PTE physical address (8-byte aligned).
- `mem_rsp_valid_i` in 1: response strobe. No ready signal; the response must be consumed in the cycle it arrives.
- `mem_rsp_data_i` in 64: PTE read data.
- `mem_rsp_err_i` in 1: bus error, qualified by `mem_rsp_valid_i`.
- `update_valid_o` out 1: one-cycle TLB write strobe.
- `update_vpn_o` out 27: VPN, equal to vaddr[38:12].
- `update_asid_o` out ASID_WIDTH: ASID of the update.
- `update_is_1G_o` out 1, `update_is_2M_o` out 1: page size of the update.
- `update_content_o` out 64: leaf PTE.
- `fault_o` out 1: one-cycle page-fault strobe.
- `fault_vaddr_o` out VLEN: faulting virtual address, held until the next accepted miss.

## Operation
- States: IDLE, REQ, WAIT, UPDATE, FAULT, DRAIN.
- `miss_ready_o` = (state == IDLE).
- **Miss accept** (IDLE and `miss_valid_i`): register vaddr, ASID and satp PPN; set level=2; go to REQ.
- **PTE address:** {base_ppn, vpn[level], 3'b000}.
  - base_ppn is satp PPN at level 2, otherwise the PPN of the previous PTE (bits 53:10).
  - vpn[2]=va[38:30], vpn[1]=va[29:21], vpn[0]=va[20:12].
  - Width is 44+9+3 = 56 bits. When PLEN < 56, truncate the MSBs.
- **REQ:** `mem_req_valid_o`=1 and the address is held stable. On `mem_req_ready_i` go to WAIT. Valid is never withdrawn before acceptance.
- **WAIT:** on `mem_rsp_valid_i`, register the PTE and evaluate, first matching rule wins:
  1. err, or V=0, or (R=0 and W=1) → FAULT.
  2. R=1 or X=1 (leaf):
     - level 2 with PPN[17:0]≠0 → FAULT.
     - level 1 with PPN[8:0]≠0 → FAULT.
     - otherwise → UPDATE.
  3. Pointer at level 0 → FAULT.
  4. Otherwise level−1, then REQ.
- **UPDATE** (one cycle), then IDLE:
  - `update_valid_o`=1.
  - `update_is_1G_o` = (leaf level==2); `update_is_2M_o` = (leaf level==1).
  - `update_content_o` = registered PTE.
- **FAULT** (one cycle): `fault_o`=1, then IDLE.
- **Flush:** `flush_i` is ignored in IDLE and DRAIN. In the other states:
  - UPDATE: `update_valid_o` is suppressed combinationally; next state IDLE.
  - FAULT: `fault_o` is suppressed combinationally; next state IDLE.
  - WAIT: go to DRAIN, or to IDLE if `mem_rsp_valid_i` arrives in the same cycle (that response is discarded).
  - REQ: keep requesting until accepted, then DRAIN. If accepted in the flush cycle, go directly to DRAIN.
- **DRAIN:** discard the response and go to IDLE on `mem_rsp_valid_i`. No update or fault is produced.
- `mem_rsp_valid_i` outside WAIT/DRAIN is ignored.
- The walker sets no A/D bits and performs no permission or U/G checks; the consumer of `update_content_o` does those.

## Timing
- Reset values: state IDLE, `miss_ready_o`=1, every other output 0, internal registers 0.
- Reset applies asynchronously mid-walk. Any in-flight memory response after reset is ignored.
- Latency with `mem_req_ready_i`=1 and the response one cycle after acceptance; miss accepted at cycle 0:
  - Cycle 1: first request.
  - Cycle 2: response.
  - 1G leaf: update at cycle 3; `miss_ready_o` back to 1 at cycle 4.
  - 2M leaf: update at cycle 5.
  - 4K leaf: update at cycle 7.
- Each request stall cycle or response delay cycle adds one cycle.
- At most one request is outstanding.
- `update_*` and `fault_vaddr_o` are register outputs. `update_valid_o` and `fault_o` are state decodes, gated by `flush_i`.

## Test plan
- **4K walk:** satp_ppn=0x80000, vaddr=0x0040201000, ASID=1, responses 0x20000401, 0x20000801, 0x200400CF.
  - Request addresses: 0x80000008, 0x80001008, 0x80002008.
  - Update: vpn=0x40201, is_1G=0, is_2M=0, content=0x200400CF, asid=1, at cycle 7.
- **1G leaf:** same miss, first response 0x200000CF (PPN 0x80000, aligned).
  - One request only; update at cycle 3 with is_1G=1.
- **Misaligned 2M:** level-1 response 0x200004CF (PPN[8:0]=1).
  - `fault_o` for one cycle, `fault_vaddr_o`=0x0040201000, no update.
- **Invalid and error:** level-2 PTE 0x0 → fault after one request. A separate run with level-0 `mem_rsp_err_i`=1 → fault, no update.
- **Backpressure:** `mem_req_ready_i` low for 3 cycles.
  - Request valid and address stable throughout.
  - 4K update at cycle 10; `miss_ready_o` stays 0 until the walk ends.
- **Flush:** `flush_i` pulsed in WAIT at level 1, response 2 cycles later.
  - DRAIN consumes the response; no update and no fault.
  - `miss_ready_o`=1 the cycle after the response.
  - A back-to-back new miss then completes normally.
